// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/bubble/flush/redirect sequencer for the 3-stage core.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module hazard_ctrl #(
    parameter int LD_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_we,
    input  logic             do_jump,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             stall_if,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             pc_redirect,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT} state_t;
    state_t state, state_nx, eff;
    logic [1:0] cnt, cnt_nx;
    logic resume, resume_nx;
    logic hazard, mem_wait;

    assign mem_wait = imem_stall | dmem_stall;
    assign hazard = ex_valid & ex_is_load & ex_reg_we & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // A finished wait resolves to the state it interrupted and is evaluated in the same cycle.
    always_comb begin
        eff = (state == MEM_WAIT && !mem_wait) ? (resume ? LD_STALL : RUN) : state;
        stall_if = 1'b0;
        stall_ex = 1'b0;
        bubble_ex = 1'b0;
        flush_id = 1'b0;
        pc_redirect = 1'b0;
        state_nx = RUN;
        cnt_nx = cnt;
        resume_nx = 1'b0;
        if (rst) begin
            bubble_ex = 1'b1;
            flush_id = 1'b1;
            cnt_nx = 2'd0;
        end else if (mem_wait) begin
            stall_if = 1'b1;
            stall_ex = 1'b1;
            state_nx = MEM_WAIT;
            resume_nx = (state == LD_STALL) | ((state == MEM_WAIT) & resume);
        end else if (eff == LD_STALL) begin
            stall_if = 1'b1;
            bubble_ex = 1'b1;
            cnt_nx = cnt - 2'd1;
            state_nx = (cnt < 2'd2) ? RUN : LD_STALL;
        end else if (do_jump & ex_valid) begin
            pc_redirect = 1'b1;
            flush_id = 1'b1;
        end else if (hazard) begin
            stall_if = 1'b1;
            bubble_ex = 1'b1;
            cnt_nx = 2'(LD_BUBBLES - 1);
            state_nx = (LD_BUBBLES > 1) ? LD_STALL : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt <= 2'd0;
            resume <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            resume <= resume_nx;
        end
    end

`ifdef PIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count <= '0;
        end else begin
            stall_cycles <= stall_cycles + CNT_W'(stall_if);
            flush_count <= flush_count + CNT_W'(pc_redirect);
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: checks two hazard_ctrl instances (LD_BUBBLES=1 and 3) against a
// bubbles-owed reference model, with directed scenarios followed by random traffic.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_valid, ex_is_load, ex_reg_we, do_jump, imem_stall, dmem_stall;
    logic [4:0] o1, o3;
    logic [31:0] sc1, fc1, sc3, fc3;
    int checks = 0;
    int failures = 0;
    int owed [2];
    logic [31:0] sc_m [2];
    logic [31:0] fc_m [2];

    always #5 clk = ~clk;

    hazard_ctrl #(.LD_BUBBLES(1)) u1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we), .do_jump(do_jump), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .stall_if(o1[4]), .stall_ex(o1[3]), .bubble_ex(o1[2]), .flush_id(o1[1]),
        .pc_redirect(o1[0]), .stall_cycles(sc1), .flush_count(fc1)
    );

    hazard_ctrl #(.LD_BUBBLES(3)) u3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we), .do_jump(do_jump), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .stall_if(o3[4]), .stall_ex(o3[3]), .bubble_ex(o3[2]), .flush_id(o3[1]),
        .pc_redirect(o3[0]), .stall_cycles(sc3), .flush_count(fc3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int ldb(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Outputs ordered {stall_if, stall_ex, bubble_ex, flush_id, pc_redirect}.
    function automatic logic [4:0] model_out(input int i);
        logic haz;
        haz = ex_valid && ex_is_load && ex_reg_we && ex_rd != 0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (rst) return 5'b00110;
        if (imem_stall || dmem_stall) return 5'b11000;
        if (owed[i] > 0) return 5'b10100;
        if (do_jump && ex_valid) return 5'b00011;
        if (haz) return 5'b10100;
        return 5'b00000;
    endfunction

    task automatic step(input string tag = "", input logic [4:0] w1 = 5'b0, input logic [4:0] w3 = 5'b0);
        logic [4:0] e [2];
        int nxt [2];
        #1;
        for (int i = 0; i < 2; i++) begin
            e[i] = model_out(i);
            if (rst) nxt[i] = 0;
            else if (imem_stall || dmem_stall) nxt[i] = owed[i];
            else if (owed[i] > 0) nxt[i] = owed[i] - 1;
            else if (e[i][2]) nxt[i] = ldb(i) - 1;
            else nxt[i] = owed[i];
        end
        check("out1", {27'd0, o1}, {27'd0, e[0]});
        check("out3", {27'd0, o3}, {27'd0, e[1]});
`ifdef PIPE_PERF_EN
        check("stall_cycles1", sc1, sc_m[0]);
        check("flush_count1", fc1, fc_m[0]);
        check("stall_cycles3", sc3, sc_m[1]);
        check("flush_count3", fc3, fc_m[1]);
`else
        check("stall_cycles1", sc1, 32'd0);
        check("flush_count3", fc3, 32'd0);
`endif
        if (tag != "") begin
            check({tag, "_1"}, {27'd0, o1}, {27'd0, w1});
            check({tag, "_3"}, {27'd0, o3}, {27'd0, w3});
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            owed[i] = nxt[i];
            sc_m[i] = rst ? 32'd0 : sc_m[i] + {31'd0, e[i][4]};
            fc_m[i] = rst ? 32'd0 : fc_m[i] + {31'd0, e[i][0]};
        end
        #1;
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_valid, ex_is_load, ex_reg_we, do_jump, imem_stall, dmem_stall} = '0;
    endtask

    task automatic load_use(input logic [4:0] rd);
        ex_valid = 1; ex_is_load = 1; ex_reg_we = 1; ex_rd = rd;
        id_use_rs2 = 1; id_rs2 = rd;
    endtask

    function automatic logic [4:0] rreg();
        int k;
        k = $urandom_range(0, 3);
        return (k == 0) ? 5'd0 : (k == 1) ? 5'd5 : (k == 2) ? 5'd7 : 5'($urandom);
    endfunction

    initial begin
        idle();
        rst = 1;
        owed = '{0, 0};
        sc_m = '{32'd0, 32'd0};
        fc_m = '{32'd0, 32'd0};
        @(posedge clk);
        #1;
        step("reset", 5'b00110, 5'b00110);
        rst = 0;
        load_use(5'd5);
        step("ld_use", 5'b10100, 5'b10100);
        idle();
        step("ld_done", 5'b00000, 5'b10100);
        step();
        step();
        load_use(5'd0);
        step("ld_x0", 5'b00000, 5'b00000);
        load_use(5'd5); ex_reg_we = 0;
        step("no_we", 5'b00000, 5'b00000);
        load_use(5'd5); id_use_rs2 = 0; id_rs1 = 5'd5;
        step("no_use", 5'b00000, 5'b00000);
        load_use(5'd5); do_jump = 1;
        step("jump_haz", 5'b00011, 5'b00011);
        idle(); ex_valid = 1; do_jump = 1; dmem_stall = 1;
        for (int i = 0; i < 3; i++) step("dwait", 5'b11000, 5'b11000);
        dmem_stall = 0;
        step("dwait_jump", 5'b00011, 5'b00011);
        idle();
        load_use(5'd7);
        step("ld3_first", 5'b10100, 5'b10100);
        idle(); imem_stall = 1;
        step("ld3_wait", 5'b11000, 5'b11000);
        imem_stall = 0;
        step("ld3_b2", 5'b00000, 5'b10100);
        step("ld3_b3", 5'b00000, 5'b10100);
        step("ld3_end", 5'b00000, 5'b00000);
        load_use(5'd7);
        step("rst_ld", 5'b10100, 5'b10100);
        idle(); rst = 1;
        step("rst_mid", 5'b00110, 5'b00110);
        rst = 0;
        step("after_rst", 5'b00000, 5'b00000);
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            ex_rd = rreg(); id_rs1 = rreg(); id_rs2 = rreg();
            id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
            ex_valid = ($urandom_range(0, 4) != 0);
            ex_is_load = ($urandom_range(0, 2) != 0);
            ex_reg_we = ($urandom_range(0, 4) != 0);
            do_jump = ($urandom_range(0, 5) == 0);
            imem_stall = ($urandom_range(0, 7) == 0);
            dmem_stall = ($urandom_range(0, 7) == 0);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
